ascii_sym_decoder: RTL and testbench
====================================

// Module: ascii_sym_decoder
// PURPOSE
//   Receive-side counterpart of the one-per-second ASCII symbol generator. Samples an
//   8-bit ASCII character bus and accepts a character once it has been stable. Decodes
//   'A'-'F','0'-'9' back to the 4-bit symbol index and checks that successive symbols
//   follow the generator's increment-by-one sequence. Sits between ui_in and board-level
//   status/debug logic.
// PARAMETERS
//   STABLE_CYCLES  4  consecutive identical samples required to accept a char (1..255)
//   ERR_W          8  width of the saturating error counter (>=1)
// PORTS
//   clk        in   1      clock
//   rst_n      in   1      asynchronous active-low reset
//   char_in    in   8      ASCII character bus (sampled every clk edge)
//   sym_valid  out  1      one-cycle pulse: new character accepted
//   sym_value  out  4      decoded index of last accepted char
//   sym_legal  out  1      last accepted char was in the alphabet
//   seq_ok     out  1      last accepted symbol == previous symbol + 1 (mod 16)
//   locked     out  1      a legal symbol has been seen since reset/last illegal char
//   err_count  out  ERR_W  saturating count of sequence/illegal errors
// BEHAVIOUR
//   - Reset (async, rst_n=0): all outputs 0; internal cand=8'h00, cnt=0, no last char.
//   - Stability filter: cand register + sample counter cnt.
//     char_in != cand -> cand<=char_in, cnt<=1. char_in == cand and cnt<STABLE_CYCLES -> cnt++.
//     Char is qualified on the edge where its STABLE_CYCLES-th consecutive identical sample
//     is taken (cnt saturates; no re-qualification while held).
//   - Acceptance on qualification only if char != 8'h00 (idle/blank: ignored entirely, no
//     pulse, no error) and char != last accepted char (first acceptance after reset always
//     proceeds). Glitches shorter than STABLE_CYCLES, or returning to the last accepted
//     char, produce nothing.
//   - On acceptance all outputs update at that edge; sym_valid high for exactly one cycle.
//     Other outputs hold until the next acceptance. Latency: sym_valid rises STABLE_CYCLES-1
//     edges after the first edge sampling the new char.
//   - Decode: 8'h41-8'h46 ('A'-'F') -> 0-5; 8'h30-8'h39 ('0'-'9') -> 6-15.
//     Any other char: sym_legal=0, sym_value=0.
//   - Sequence check on legal char:
//     locked=0 -> locked<=1, seq_ok<=0, no error.
//     locked=1, value==(prev+1)%16 -> seq_ok<=1. This includes wrap 15('9') -> 0('A').
//     locked=1, value mismatch -> seq_ok<=0, err++, locked stays 1, prev<=value (resync).
//   - Illegal char: seq_ok<=0, locked<=0, err++.
//   - err_count saturates at all-ones; never wraps.
//   - Reset mid-filter or mid-sequence aborts any pending qualification; no pulse is
//     emitted; next acceptance after release is treated as first.
// CONFIGURATION
//   SYM_DEC_ERR_CLEAR_EN defined: extra port err_clr (in, 1). Synchronous clear of
//   err_count to 0, taking priority over a same-cycle increment; other state unaffected.
//   Not defined: no err_clr port; err_count is cleared only by rst_n.
// TESTING  (STABLE_CYCLES=4, ERR_W=8 unless noted)
//   1. Reset, hold 8'h41 for 6 clks -> single sym_valid pulse 3 edges after first sample;
//      sym_value=0, sym_legal=1, locked=1, seq_ok=0, err_count=0.
//   2. Sweep 'A'..'F','0'..'9','A', each held 8 clks -> 17 pulses; seq_ok=1 from 2nd on,
//      including '9'->'A' wrap; err_count=0.
//   3. Hold 'B', inject 8'h5A for 2 clks, return to 'B'; then hold 8'h00 -> no pulse,
//      outputs unchanged.
//   4. 'C' then 'Z'(8'h5A) then 'D' -> 'Z' pulse: sym_legal=0, locked=0, err=1;
//      'D' pulse: locked=1, seq_ok=0, err stays 1.
//   5. 'A' then 'C' then 'D' -> 'C': seq_ok=0, err=1; 'D': seq_ok=1. ERR_W=2 with 5
//      alternating 'Z','Y' -> err_count=3 (saturated).
//   6. rst_n low at cnt=2 -> all outputs 0, no pulse. With SYM_DEC_ERR_CLEAR_EN: err_clr
//      coincident with an error -> err_count=0.

Source files
------------

// File: rtl/ascii_sym_decoder.sv
// ascii_sym_decoder: filters a sampled ASCII bus, decodes 'A'-'F','0'-'9' to a 4-bit index, checks +1 sequence.
// Latency: sym_valid rises STABLE_CYCLES-1 edges after the first edge sampling a new character.
// Backpressure: none; the bus is sampled every cycle. Optional macro SYM_DEC_ERR_CLEAR_EN adds err_clr.
module ascii_sym_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SYM_DEC_ERR_CLEAR_EN
  input  logic             err_clr,
`endif
  input  logic [7:0]       char_in,
  output logic             sym_valid,
  output logic [3:0]       sym_value,
  output logic             sym_legal,
  output logic             seq_ok,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [7:0] STABLE_N  = 8'(STABLE_CYCLES);
  localparam logic [7:0] STABLE_M1 = 8'(STABLE_CYCLES - 1);

  logic [7:0]       r_cand;
  logic [7:0]       r_cnt;
  logic [7:0]       r_last;
  logic             r_have_last;
  logic             r_sym_valid;
  logic [3:0]       r_sym_value;
  logic             r_sym_legal;
  logic             r_seq_ok;
  logic             r_locked;
  logic [ERR_W-1:0] r_err;

  logic             w_qual;
  logic             w_accept;
  logic             w_legal;
  logic [3:0]       w_value;
  logic [3:0]       w_next;
  logic             w_err_inc;
  logic             w_err_clr;

`ifdef SYM_DEC_ERR_CLEAR_EN
  assign w_err_clr = err_clr;
`else
  assign w_err_clr = 1'b0;
`endif

  // A change restarts the run at one sample; the run qualifies on its STABLE_CYCLES-th sample only,
  // since the counter saturates and a held character never re-qualifies.
  assign w_qual = (char_in != r_cand) ? (STABLE_CYCLES == 1) : (r_cnt == STABLE_M1);

  // Blank (8'h00) is ignored, and so is a return to the character we already reported.
  assign w_accept = w_qual && (char_in != 8'h00) && (!r_have_last || (char_in != r_last));

  assign w_next = r_sym_value + 4'd1;

  // Alphabet decode: 'A'-'F' -> 0-5, '0'-'9' -> 6-15, anything else illegal with value 0.
  always_comb begin
    w_legal = 1'b0;
    w_value = 4'd0;
    if (char_in >= 8'h41 && char_in <= 8'h46) begin
      w_legal = 1'b1;
      w_value = 4'(char_in - 8'h41);
    end else if (char_in >= 8'h30 && char_in <= 8'h39) begin
      w_legal = 1'b1;
      w_value = 4'(char_in - 8'h30 + 8'd6);
    end
  end

  // Errors: any illegal char, or a legal char breaking the +1 chain while locked.
  assign w_err_inc = w_accept && (!w_legal || (r_locked && (w_value != w_next)));

  // Stability filter: candidate character and its consecutive-sample count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand <= 8'h00;
      r_cnt  <= 8'd0;
    end else if (char_in != r_cand) begin
      r_cand <= char_in;
      r_cnt  <= 8'd1;
    end else if (r_cnt < STABLE_N) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Symbol state: updated only on acceptance; a mismatch resyncs prev to the new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last      <= 8'h00;
      r_have_last <= 1'b0;
      r_sym_valid <= 1'b0;
      r_sym_value <= 4'd0;
      r_sym_legal <= 1'b0;
      r_seq_ok    <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_sym_valid <= w_accept;
      if (w_accept) begin
        r_last      <= char_in;
        r_have_last <= 1'b1;
        r_sym_value <= w_value;
        r_sym_legal <= w_legal;
        if (w_legal) begin
          r_seq_ok <= r_locked && (w_value == w_next);
          r_locked <= 1'b1;
        end else begin
          r_seq_ok <= 1'b0;
          r_locked <= 1'b0;
        end
      end
    end
  end

  // Saturating error counter; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= '0;
    end else if (w_err_clr) begin
      r_err <= '0;
    end else if (w_err_inc && (r_err != {ERR_W{1'b1}})) begin
      r_err <= r_err + 1'b1;
    end
  end

  assign sym_valid = r_sym_valid;
  assign sym_value = r_sym_value;
  assign sym_legal = r_sym_legal;
  assign seq_ok    = r_seq_ok;
  assign locked    = r_locked;
  assign err_count = r_err;

endmodule

// File: tb/tb_ascii_sym_decoder.sv
// Directed bench for ascii_sym_decoder (STABLE_CYCLES=4; ERR_W=8 main instance, ERR_W=2 saturation instance).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Builds with or without SYM_DEC_ERR_CLEAR_EN.
module tb_ascii_sym_decoder;

  logic       clk;
  logic       rst_n;
  logic       err_clr;
  logic [7:0] char_in;

  logic       sym_valid, sym_legal, seq_ok, locked;
  logic [3:0] sym_value;
  logic [7:0] err_count;

  logic       sym_valid2, sym_legal2, seq_ok2, locked2;
  logic [3:0] sym_value2;
  logic [1:0] err_count2;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  ascii_sym_decoder #(.STABLE_CYCLES(4), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef SYM_DEC_ERR_CLEAR_EN
    .err_clr(err_clr),
`endif
    .char_in(char_in), .sym_valid(sym_valid), .sym_value(sym_value), .sym_legal(sym_legal),
    .seq_ok(seq_ok), .locked(locked), .err_count(err_count)
  );

  ascii_sym_decoder #(.STABLE_CYCLES(4), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
`ifdef SYM_DEC_ERR_CLEAR_EN
    .err_clr(err_clr),
`endif
    .char_in(char_in), .sym_valid(sym_valid2), .sym_value(sym_value2), .sym_legal(sym_legal2),
    .seq_ok(seq_ok2), .locked(locked2), .err_count(err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counter, sampled shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (sym_valid) pulse_cnt = pulse_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic hold(input logic [7:0] c, input int n);
    char_in = c;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    char_in = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    err_clr = 1'b0;
    rst_n   = 1'b0;
    char_in = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({sym_valid, sym_value, sym_legal, seq_ok, locked, err_count} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {sym_valid, sym_value, sym_legal, seq_ok, locked, err_count});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_accept();
    int p0;
    p0 = pulse_cnt;
    char_in = 8'h41;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (sym_valid !== (k == 3)) begin
        errors++;
        $display("FAIL first_latency edge%0d: sym_valid=%b required %b", k, sym_valid, (k == 3));
      end
    end
    checks++;
    if (pulse_cnt - p0 !== 1) begin
      errors++;
      $display("FAIL first_pulses: got %0d required 1", pulse_cnt - p0);
    end
    checks++;
    if ({sym_value, sym_legal, locked, seq_ok, err_count} !== {4'd0, 1'b1, 1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL first_outputs: val=%0d legal=%b locked=%b seq=%b err=%0d required 0 1 1 0 0",
               sym_value, sym_legal, locked, seq_ok, err_count);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] seq_chars [17];
    int p0;
    seq_chars = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h30, 8'h31, 8'h32,
                  8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h41};
    do_reset();
    p0 = pulse_cnt;
    for (int i = 0; i < 17; i++) begin
      hold(seq_chars[i], 8);
      checks++;
      if (sym_value !== 4'(i % 16) || seq_ok !== (i > 0) || sym_legal !== 1'b1) begin
        errors++;
        $display("FAIL sweep_step%0d: val=%0d seq=%b legal=%b required %0d %b 1",
                 i, sym_value, seq_ok, sym_legal, i % 16, (i > 0));
      end
    end
    checks++;
    if (pulse_cnt - p0 !== 17) begin
      errors++;
      $display("FAIL sweep_pulses: got %0d required 17", pulse_cnt - p0);
    end
    checks++;
    if (err_count !== 8'd0) begin
      errors++;
      $display("FAIL sweep_err: got %0d required 0", err_count);
    end
  endtask

  task automatic test_glitch_blank();
    int p0;
    hold(8'h42, 8);
    p0 = pulse_cnt;
    hold(8'h5A, 2);
    hold(8'h42, 8);
    hold(8'h00, 8);
    checks++;
    if (pulse_cnt !== p0) begin
      errors++;
      $display("FAIL glitch_pulses: got %0d extra required 0", pulse_cnt - p0);
    end
    checks++;
    if ({sym_value, sym_legal, seq_ok, locked, err_count} !== {4'd1, 1'b1, 1'b1, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL glitch_outputs: val=%0d legal=%b seq=%b locked=%b err=%0d required 1 1 1 1 0",
               sym_value, sym_legal, seq_ok, locked, err_count);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    hold(8'h43, 8);
    hold(8'h5A, 8);
    checks++;
    if ({sym_value, sym_legal, locked, seq_ok, err_count} !== {4'd0, 1'b0, 1'b0, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL illegal_z: val=%0d legal=%b locked=%b seq=%b err=%0d required 0 0 0 0 1",
               sym_value, sym_legal, locked, seq_ok, err_count);
    end
    hold(8'h44, 8);
    checks++;
    if ({sym_value, sym_legal, locked, seq_ok, err_count} !== {4'd3, 1'b1, 1'b1, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL illegal_relock: val=%0d legal=%b locked=%b seq=%b err=%0d required 3 1 1 0 1",
               sym_value, sym_legal, locked, seq_ok, err_count);
    end
  endtask

  task automatic test_seq_error();
    do_reset();
    hold(8'h41, 8);
    hold(8'h43, 8);
    checks++;
    if (seq_ok !== 1'b0 || err_count !== 8'd1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL seq_skip: seq=%b err=%0d locked=%b required 0 1 1", seq_ok, err_count, locked);
    end
    hold(8'h44, 8);
    checks++;
    if (seq_ok !== 1'b1 || err_count !== 8'd1 || sym_value !== 4'd3) begin
      errors++;
      $display("FAIL seq_resync: seq=%b err=%0d val=%0d required 1 1 3", seq_ok, err_count, sym_value);
    end
    for (int i = 0; i < 5; i++) hold((i % 2 == 0) ? 8'h5A : 8'h59, 8);
    checks++;
    if (err_count2 !== 2'd3) begin
      errors++;
      $display("FAIL err_saturate: got %0d required 3", err_count2);
    end
    checks++;
    if (err_count !== 8'd6) begin
      errors++;
      $display("FAIL err_count_wide: got %0d required 6", err_count);
    end
  endtask

  task automatic test_reset_midfilter();
    int p0;
    do_reset();
    hold(8'h41, 8);
    hold(8'h45, 2);
    p0 = pulse_cnt;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({sym_valid, sym_value, sym_legal, seq_ok, locked, err_count} !== 16'h0 || pulse_cnt !== p0) begin
      errors++;
      $display("FAIL midfilter_reset: outs=%h pulses=%0d required 0 0",
               {sym_valid, sym_value, sym_legal, seq_ok, locked, err_count}, pulse_cnt - p0);
    end
    rst_n = 1'b1;
    hold(8'h45, 6);
    checks++;
    if (pulse_cnt - p0 !== 1 || sym_value !== 4'd4 || locked !== 1'b1 || seq_ok !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_first: pulses=%0d val=%0d locked=%b seq=%b required 1 4 1 0",
               pulse_cnt - p0, sym_value, locked, seq_ok);
    end
  endtask

`ifdef SYM_DEC_ERR_CLEAR_EN
  task automatic test_err_clear();
    hold(8'h5A, 8);
    checks++;
    if (err_count !== 8'd1) begin
      errors++;
      $display("FAIL clr_setup: got %0d required 1", err_count);
    end
    hold(8'h59, 3);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (err_count !== 8'd0 || sym_valid !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL clr_priority: err=%0d valid=%b locked=%b required 0 1 0", err_count, sym_valid, locked);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_accept();
    test_sweep();
    test_glitch_blank();
    test_illegal();
    test_seq_error();
    test_reset_midfilter();
`ifdef SYM_DEC_ERR_CLEAR_EN
    test_err_clear();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
